mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the single SoC memory bus between N requesters: debug unit, CPU data port, CPU instruction port, and spares.
- The bus covers RAM, MMIO and ROM, with an OR-combined read bus.
- Requester 0 (debug) has fixed absolute priority. Requesters 1..N-1 are served round-robin.
- One transaction is in flight at a time. The block sequences issue, waits a fixed memory latency, then returns data with a one-cycle ack pulse.
- Replaces the ad-hoc debug/CPU address mux in the SoC top level.

Parameters:
- N_REQ, 3: number of requesters (2..8). Index 0 is the priority requester.
- MEM_LAT, 1: cycles from the mem_op cycle to mem_do valid (1..4).
- AW, 32: address width.

Ports:
- clk, input, 1: system clock.
- n_reset, input, 1: asynchronous active-low reset.
- req, input, N_REQ: per-requester request. Held high with stable adr/wdata/wren until ack.
- req_adr, input, N_REQ*AW: packed byte addresses. Requester i occupies [i*AW +: AW].
- req_wdata, input, N_REQ*32: packed write data.
- req_wren, input, N_REQ*4: packed byte write enables. All-zero means read.
- ack, output, N_REQ: one-cycle completion pulse to the granted requester.
- rdata, output, 32: read data, valid only in the ack cycle. Shared by all requesters.
- busy, output, 1: high while a transaction is in flight.
- gnt_id, output, 3: index of the current or last granted requester.
- mem_op, output, 1: bus select strobe, high exactly one cycle per transaction.
- mem_adr, output, AW: address to memory decode.
- mem_di, output, 32: write data to memory.
- mem_wren, output, 4: byte write enables to memory.
- mem_do, input, 32: OR-combined read data from slaves.

Behaviour:
- Reset (async assert, sync deassert on clk):
  - state=IDLE.
  - ack=0, mem_op=0, busy=0, gnt_id=0.
  - mem_adr/mem_di/mem_wren=0.
  - Round-robin pointer = 1.
- States:
  - IDLE → ISSUE when any eligible req is high.
  - ISSUE → WAIT if MEM_LAT>1, else → RESP.
  - WAIT counts MEM_LAT-1 cycles, then → RESP.
  - RESP → ISSUE if any eligible req, else → IDLE.
- Arbitration happens in IDLE and in RESP.
  - If req[0] is eligible it wins.
  - Otherwise the first eligible req at or after the pointer among 1..N_REQ-1 wins, searching cyclically.
  - Winner index, adr, wdata and wren are registered into gnt_id and the mem_* registers on the transition into ISSUE.
  - Pointer advances to winner+1, wrapping N_REQ-1 → 1, only when a non-zero requester wins.
- Eligibility: in RESP, the requester being acked that cycle is masked because its req is still high. All other requests are eligible.
  - A lone requester therefore gets at most one transaction per 2+MEM_LAT cycles.
- ISSUE cycle:
  - mem_op=1, driven from registers.
  - mem_wren is nonzero only in ISSUE. Outside ISSUE mem_wren=0 and mem_op=0, so the OR bus reads zero.
- RESP cycle:
  - ack[gnt_id]=1 and rdata=mem_do.
  - rdata=0 in all other cycles.
  - Writes are also acked in RESP: uniform latency, fire-and-forget not allowed.
- Latency: req seen high in IDLE at cycle t → mem_op at t+1 → ack at t+1+MEM_LAT.
- busy=1 in ISSUE, WAIT and RESP.
- No preemption. A req[0] arriving mid-transaction waits for RESP, then wins over all others.
- A req dropped after grant: the transaction still completes on the bus and ack still pulses. The requester ignores it.
- Simultaneous req[0] and others in IDLE: 0 wins and the pointer is unchanged.
- n_reset asserted mid-transaction: immediate return to the reset state. No ack is issued and the partial bus cycle is abandoned. Memory write safety is the owner's concern.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE/ST_ISSUE/ST_WAIT/ST_RESP.
  - MEM_LAT default.
  - the SoC address-map constants already used for RAM/MMIO/ROM decode.
- One sub-module, rr_pick: combinational round-robin picker. Inputs are eligible mask and pointer; outputs are winner index and valid. Keeps the priority logic separately testable.

Test Plan:
- Single read: req[1]=1, adr=0x00000010, mem_do=0xDEADBEEF, MEM_LAT=1 → mem_op pulse at t+1 with mem_adr=0x10 and mem_wren=0. Then ack[1]=1 with rdata=0xDEADBEEF at t+2, and rdata=0 at t+3.
- Write: req[2]=1, adr=0x00010004, wdata=0x55, wren=4'b0001 → mem_wren=0001 only in the ISSUE cycle. ack[2] at t+2.
- Priority: req[0], req[1] and req[2] all rise in the same IDLE cycle → grant order 0,1,2. Pointer ends at 1. No gap beyond one RESP→ISSUE step.
- Round-robin fairness: req[1] and req[2] held continuously for 6 transactions → acks alternate 1,2,1,2,1,2. A held lone req[1] → an ack every 3 cycles (MEM_LAT=1).
- Latency parameter: MEM_LAT=3, read → ack exactly 3 cycles after the mem_op cycle. busy high for 4 cycles.
- Reset mid-flight: n_reset low during WAIT → ack, mem_op and busy go 0 immediately. After release, a held req is re-arbitrated from IDLE with the pointer reset to 1.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg
//   Shared definitions for the SoC memory bus arbiter:
//   - FSM state encoding (ST_IDLE / ST_ISSUE / ST_WAIT / ST_RESP)
//   - default memory latency
//   - SoC address-map constants used by the RAM/MMIO/ROM decode
//   - round-robin pointer advance helper
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam int MEM_LAT_DEFAULT = 1;

  // SoC address map (byte addresses).
  localparam logic [31:0] RAM_BASE  = 32'h0000_0000;
  localparam logic [31:0] RAM_MASK  = 32'hFFFF_0000;
  localparam logic [31:0] MMIO_BASE = 32'h0001_0000;
  localparam logic [31:0] MMIO_MASK = 32'hFFFF_0000;
  localparam logic [31:0] ROM_BASE  = 32'hFFFF_0000;
  localparam logic [31:0] ROM_MASK  = 32'hFFFF_0000;

  // Pointer moves to the slot after the winner; the round-robin ring is
  // 1..last, requester 0 is never part of it.
  function automatic logic [2:0] rr_advance(input logic [2:0] win,
                                            input logic [2:0] last);
    return (win == last) ? 3'd1 : win + 3'd1;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_pick.sv
// mem_bus_arbiter_rr_pick
//   Combinational round-robin picker over requesters 1..N_REQ-1.
//   Ports:
//     elig_i  [N_REQ-1:1] eligible requests (bit i = requester i)
//     ptr_i   [2:0]       first index to consider (1..N_REQ-1)
//     win_o   [2:0]       winning index (0 when nothing is eligible)
//     valid_o             a winner exists
module mem_bus_arbiter_rr_pick #(
  parameter int N_REQ = 3
) (
  input  logic [N_REQ-1:1] elig_i,
  input  logic [2:0]       ptr_i,
  output logic [2:0]       win_o,
  output logic             valid_o
);

  // Index reached after stepping 'off' slots from p around the ring 1..N_REQ-1.
  function automatic int wrap_idx(input logic [2:0] p, input int off);
    int c;
    c = int'({29'd0, p}) + off;
    if (c >= N_REQ) c = c - (N_REQ - 1);
    return c;
  endfunction

  always_comb begin
    win_o   = 3'd0;
    valid_o = 1'b0;
    for (int off = 0; off < N_REQ - 1; off++) begin
      for (int i = 1; i < N_REQ; i++) begin
        if (!valid_o && elig_i[i] && (wrap_idx(ptr_i, off) == i)) begin
          valid_o = 1'b1;
          win_o   = 3'(i);
        end
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares the single SoC memory bus between N_REQ requesters. Requester 0
//   (debug) has absolute priority, 1..N_REQ-1 are served round-robin. One
//   transaction in flight: ISSUE (mem_op strobe), MEM_LAT-1 WAIT cycles,
//   RESP (ack pulse + rdata).
//
//   Handshake: a requester raises req[i] and holds req_adr/req_wdata/req_wren
//   stable until it sees ack[i] high for one cycle; rdata is valid only in
//   that ack cycle. Dropping req after grant does not cancel the transaction.
//
//   Ports:
//     clk, n_reset              clock, async active-low reset
//     req       [N_REQ]         per-requester request
//     req_adr   [N_REQ*AW]      packed addresses, requester i at [i*AW +: AW]
//     req_wdata [N_REQ*32]      packed write data
//     req_wren  [N_REQ*4]       packed byte enables (all zero = read)
//     ack       [N_REQ]         one-cycle completion pulse
//     rdata     [32]            read data, zero outside the ack cycle
//     busy                      transaction in flight
//     gnt_id    [3]             current / last granted requester
//     mem_op                    bus strobe, one cycle per transaction
//     mem_adr, mem_di, mem_wren address, write data, byte enables to memory
//     mem_do    [32]            OR-combined read data from slaves
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int N_REQ   = 3,
  parameter int MEM_LAT = MEM_LAT_DEFAULT,
  parameter int AW      = 32
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic [N_REQ-1:0]  req,
  input  logic [N_REQ*AW-1:0] req_adr,
  input  logic [N_REQ*32-1:0] req_wdata,
  input  logic [N_REQ*4-1:0]  req_wren,
  output logic [N_REQ-1:0]  ack,
  output logic [31:0]       rdata,
  output logic              busy,
  output logic [2:0]        gnt_id,
  output logic              mem_op,
  output logic [AW-1:0]     mem_adr,
  output logic [31:0]       mem_di,
  output logic [3:0]        mem_wren,
  input  logic [31:0]       mem_do
);

  localparam logic [1:0] LAT_M2   = 2'((MEM_LAT >= 2) ? MEM_LAT - 2 : 0);
  localparam logic [2:0] LAST_IDX = 3'(N_REQ - 1);

  state_t        state_q, state_d;
  logic [2:0]    gnt_q, gnt_d;
  logic [2:0]    ptr_q, ptr_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [31:0]   di_q, di_d;
  logic [3:0]    we_q, we_d;
  logic [1:0]    cnt_q, cnt_d;

  logic [N_REQ-1:0] ack_vec;
  logic [N_REQ-1:0] elig;
  logic [2:0]       rr_win;
  logic             rr_valid;
  logic [2:0]       win;
  logic             win_valid;
  logic [AW-1:0]    sel_adr;
  logic [31:0]      sel_di;
  logic [3:0]       sel_we;

  always_comb begin
    ack_vec = '0;
    for (int i = 0; i < N_REQ; i++) begin
      ack_vec[i] = (state_q == ST_RESP) && (gnt_q == 3'(i));
    end
  end

  // The requester being acked still holds req this cycle; masking it stops
  // it from being granted a second, phantom transaction.
  assign elig = req & ~ack_vec;

  mem_bus_arbiter_rr_pick #(
    .N_REQ(N_REQ)
  ) u_rr_pick (
    .elig_i (elig[N_REQ-1:1]),
    .ptr_i  (ptr_q),
    .win_o  (rr_win),
    .valid_o(rr_valid)
  );

  always_comb begin
    win       = rr_win;
    win_valid = rr_valid;
    if (elig[0]) begin
      win       = 3'd0;
      win_valid = 1'b1;
    end
  end

  always_comb begin
    sel_adr = '0;
    sel_di  = '0;
    sel_we  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win == 3'(i)) begin
        sel_adr = req_adr[i*AW +: AW];
        sel_di  = req_wdata[i*32 +: 32];
        sel_we  = req_wren[i*4 +: 4];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    adr_d   = adr_q;
    di_d    = di_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (win_valid) begin
          state_d = ST_ISSUE;
          gnt_d   = win;
          adr_d   = sel_adr;
          di_d    = sel_di;
          we_d    = sel_we;
          if (win != 3'd0) ptr_d = rr_advance(win, LAST_IDX);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (MEM_LAT > 1) begin
          state_d = ST_WAIT;
          cnt_d   = 2'd0;
        end else begin
          state_d = ST_RESP;
        end
      end
      ST_WAIT: begin
        if (cnt_q == LAT_M2) state_d = ST_RESP;
        else                 cnt_d   = cnt_q + 2'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= ST_IDLE;
      gnt_q   <= 3'd0;
      ptr_q   <= 3'd1;
      adr_q   <= '0;
      di_q    <= '0;
      we_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      adr_q   <= adr_d;
      di_q    <= di_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
    end
  end

  // Strobe and byte enables are gated to ISSUE so every slave stays off the
  // OR-combined read bus in all other cycles.
  assign mem_op   = (state_q == ST_ISSUE);
  assign mem_wren = mem_op ? we_q : 4'd0;
  assign mem_adr  = adr_q;
  assign mem_di   = di_q;
  assign busy     = (state_q != ST_IDLE);
  assign gnt_id   = gnt_q;
  assign ack      = ack_vec;
  assign rdata    = (state_q == ST_RESP) ? mem_do : 32'd0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic n_reset = 1'b0;
  logic n_reset3 = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT with MEM_LAT=1 (table-driven) ----------------
  logic [2:0]  req = '0;
  logic [95:0] req_adr = '0;
  logic [95:0] req_wdata = '0;
  logic [11:0] req_wren = '0;
  logic [2:0]  ack;
  logic [31:0] rdata;
  logic        busy;
  logic [2:0]  gnt_id;
  logic        mem_op;
  logic [31:0] mem_adr;
  logic [31:0] mem_di;
  logic [3:0]  mem_wren;
  logic [31:0] mem_do = '0;

  mem_bus_arbiter #(.N_REQ(3), .MEM_LAT(1), .AW(32)) dut (
    .clk(clk), .n_reset(n_reset), .req(req), .req_adr(req_adr),
    .req_wdata(req_wdata), .req_wren(req_wren), .ack(ack), .rdata(rdata),
    .busy(busy), .gnt_id(gnt_id), .mem_op(mem_op), .mem_adr(mem_adr),
    .mem_di(mem_di), .mem_wren(mem_wren), .mem_do(mem_do)
  );

  // ---------------- DUT with MEM_LAT=3 (hand sequences) ----------------
  logic [2:0]  req3 = '0;
  logic [95:0] adr3 = '0;
  logic [95:0] wd3 = '0;
  logic [11:0] we3 = '0;
  logic [2:0]  ack3;
  logic [31:0] rdata3;
  logic        busy3;
  logic [2:0]  gnt3;
  logic        op3;
  logic [31:0] madr3;
  logic [31:0] mdi3;
  logic [3:0]  mwe3;
  logic [31:0] mdo3 = '0;

  mem_bus_arbiter #(.N_REQ(3), .MEM_LAT(3), .AW(32)) dut3 (
    .clk(clk), .n_reset(n_reset3), .req(req3), .req_adr(adr3),
    .req_wdata(wd3), .req_wren(we3), .ack(ack3), .rdata(rdata3),
    .busy(busy3), .gnt_id(gnt3), .mem_op(op3), .mem_adr(madr3),
    .mem_di(mdi3), .mem_wren(mwe3), .mem_do(mdo3)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=0x%0h exp=0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  req;
    logic [31:0] a1, a2, wd2;
    logic [3:0]  we2;
    logic [31:0] mdo;
    logic [2:0]  e_ack;
    logic        e_op, e_busy;
    logic [2:0]  e_gnt;
    logic [31:0] e_rd, e_adr, e_di;
    logic [3:0]  e_we;
  } vec_t;

  vec_t vecs[$];

  localparam logic [31:0] A0 = 32'h100;
  localparam logic [31:0] A1 = 32'h104;
  localparam logic [31:0] A2 = 32'h108;
  localparam logic [31:0] FD = 32'h0BAD_F00D;

  task automatic v(input logic [2:0] rq, input logic [31:0] a1, input logic [31:0] a2,
                   input logic [31:0] wd2, input logic [3:0] we2, input logic [31:0] mdo,
                   input logic [2:0] eack, input logic eop, input logic ebusy,
                   input logic [2:0] egnt, input logic [31:0] erd, input logic [31:0] eadr,
                   input logic [31:0] edi, input logic [3:0] ewe);
    vec_t r;
    r.req = rq; r.a1 = a1; r.a2 = a2; r.wd2 = wd2; r.we2 = we2; r.mdo = mdo;
    r.e_ack = eack; r.e_op = eop; r.e_busy = ebusy; r.e_gnt = egnt;
    r.e_rd = erd; r.e_adr = eadr; r.e_di = edi; r.e_we = ewe;
    vecs.push_back(r);
  endtask

  // Short forms for the arbitration section (a1=A1, a2=A2, reads, mem_do=FD).
  task automatic v_idle(input logic [2:0] rq, input logic [2:0] g, input logic [31:0] a);
    v(rq, A1, A2, 0, 0, FD, 3'b000, 0, 0, g, 0, a, 0, 0);
  endtask
  task automatic v_issue(input logic [2:0] rq, input logic [2:0] g, input logic [31:0] a);
    v(rq, A1, A2, 0, 0, FD, 3'b000, 1, 1, g, 0, a, 0, 0);
  endtask
  task automatic v_resp(input logic [2:0] rq, input logic [2:0] g, input logic [31:0] a);
    logic [2:0] one_hot;
    one_hot = 3'b001 << g;
    v(rq, A1, A2, 0, 0, FD, one_hot, 0, 1, g, FD, a, 0, 0);
  endtask

  task automatic fill_vectors();
    // single read from requester 1, then rdata back to zero
    v(3'b000, 32'h10, 32'h10004, 32'h55, 4'b0001, 32'h12345678, 3'b000, 0, 0, 3'd0, 0, 0, 0, 0);
    v(3'b010, 32'h10, 32'h10004, 32'h55, 4'b0001, 32'h12345678, 3'b000, 0, 0, 3'd0, 0, 0, 0, 0);
    v(3'b010, 32'h10, 32'h10004, 32'h55, 4'b0001, 32'h12345678, 3'b000, 1, 1, 3'd1, 0, 32'h10, 0, 0);
    v(3'b010, 32'h10, 32'h10004, 32'h55, 4'b0001, 32'hDEADBEEF, 3'b010, 0, 1, 3'd1, 32'hDEADBEEF, 32'h10, 0, 0);
    v(3'b000, 32'h10, 32'h10004, 32'h55, 4'b0001, 32'hDEADBEEF, 3'b000, 0, 0, 3'd1, 0, 32'h10, 0, 0);
    // write from requester 2: byte enable visible only in ISSUE
    v(3'b100, 32'h10, 32'h10004, 32'h55, 4'b0001, 32'h0, 3'b000, 0, 0, 3'd1, 0, 32'h10, 0, 0);
    v(3'b100, 32'h10, 32'h10004, 32'h55, 4'b0001, 32'h0, 3'b000, 1, 1, 3'd2, 0, 32'h10004, 32'h55, 4'b0001);
    v(3'b100, 32'h10, 32'h10004, 32'h55, 4'b0001, 32'h0, 3'b100, 0, 1, 3'd2, 0, 32'h10004, 32'h55, 0);
    v(3'b000, 32'h10, 32'h10004, 32'h55, 4'b0001, 32'h0, 3'b000, 0, 0, 3'd2, 0, 32'h10004, 32'h55, 0);
    // all three rise together: order 0,1,2
    v(3'b111, A1, A2, 0, 0, FD, 3'b000, 0, 0, 3'd2, 0, 32'h10004, 32'h55, 0);
    v_issue(3'b111, 3'd0, A0);
    v_resp (3'b111, 3'd0, A0);
    v_issue(3'b110, 3'd1, A1);
    v_resp (3'b110, 3'd1, A1);
    v_issue(3'b100, 3'd2, A2);
    v_resp (3'b100, 3'd2, A2);
    v_idle (3'b000, 3'd2, A2);
    // pointer back at 1: 1 wins, then 1/2 alternate while both are held
    v_idle (3'b110, 3'd2, A2);
    for (int k = 0; k < 3; k++) begin
      v_issue(3'b110, 3'd1, A1);
      v_resp (3'b110, 3'd1, A1);
      v_issue(3'b110, 3'd2, A2);
      v_resp (3'b110, 3'd2, A2);
    end
    // lone held requester 1: an ack every 3 cycles
    v_issue(3'b010, 3'd1, A1);
    v_resp (3'b010, 3'd1, A1);
    v_idle (3'b010, 3'd1, A1);
    v_issue(3'b010, 3'd1, A1);
    v_resp (3'b010, 3'd1, A1);
    v_idle (3'b010, 3'd1, A1);
    v_issue(3'b010, 3'd1, A1);
    v_resp (3'b010, 3'd1, A1);
    v_idle (3'b000, 3'd1, A1);
    // requester 0 arrives mid-transaction: waits for RESP, then wins
    v_idle (3'b010, 3'd1, A1);
    v_issue(3'b011, 3'd1, A1);
    v_resp (3'b011, 3'd1, A1);
    v_issue(3'b001, 3'd0, A0);
    v_resp (3'b001, 3'd0, A0);
    v_idle (3'b000, 3'd0, A0);
    // request dropped after grant still completes with an ack
    v_idle (3'b100, 3'd0, A0);
    v_issue(3'b000, 3'd2, A2);
    v_resp (3'b000, 3'd2, A2);
    v_idle (3'b000, 3'd2, A2);
  endtask

  task automatic run_table();
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      req       = vecs[i].req;
      req_adr   = {vecs[i].a2, vecs[i].a1, A0};
      req_wdata = {vecs[i].wd2, 32'd0, 32'd0};
      req_wren  = {vecs[i].we2, 4'd0, 4'd0};
      mem_do    = vecs[i].mdo;
      #1;
      chk($sformatf("row%0d ack", i),      {29'd0, ack},      {29'd0, vecs[i].e_ack});
      chk($sformatf("row%0d mem_op", i),   {31'd0, mem_op},   {31'd0, vecs[i].e_op});
      chk($sformatf("row%0d busy", i),     {31'd0, busy},     {31'd0, vecs[i].e_busy});
      chk($sformatf("row%0d gnt_id", i),   {29'd0, gnt_id},   {29'd0, vecs[i].e_gnt});
      chk($sformatf("row%0d rdata", i),    rdata,             vecs[i].e_rd);
      chk($sformatf("row%0d mem_adr", i),  mem_adr,           vecs[i].e_adr);
      chk($sformatf("row%0d mem_di", i),   mem_di,            vecs[i].e_di);
      chk($sformatf("row%0d mem_wren", i), {28'd0, mem_wren}, {28'd0, vecs[i].e_we});
    end
    @(negedge clk);
    req = '0;
  endtask

  // MEM_LAT=3: ack exactly 3 cycles after mem_op, busy for 4 cycles.
  task automatic lat3_read();
    int op_cyc, ack_cyc, busy_n, op_n;
    op_cyc = -1; ack_cyc = -1; busy_n = 0; op_n = 0;
    @(negedge clk);
    req3 = 3'b010;
    adr3 = {32'h0, 32'h20, 32'h0};
    mdo3 = 32'h1122_3344;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (busy3) busy_n++;
      if (op3) begin
        op_n++;
        op_cyc = c;
        chk("lat3 mem_adr", madr3, 32'h20);
      end
      if (ack3 != 3'b000) begin
        ack_cyc = c;
        chk("lat3 ack vec", {29'd0, ack3}, 32'd2);
        chk("lat3 rdata", rdata3, 32'h1122_3344);
        break;
      end
      @(negedge clk);
    end
    chk("lat3 ack seen", {31'd0, ack_cyc >= 0}, 32'd1);
    chk("lat3 ack-op distance", 32'(ack_cyc - op_cyc), 32'd3);
    chk("lat3 busy cycles", 32'(busy_n), 32'd4);
    chk("lat3 op pulses", 32'(op_n), 32'd1);
    @(negedge clk);
    req3 = 3'b000;
    #1;
    chk("lat3 idle busy", {31'd0, busy3}, 32'd0);
    chk("lat3 idle rdata", rdata3, 32'd0);
  endtask

  // Reset during WAIT: outputs drop at once, pointer returns to 1.
  task automatic lat3_reset();
    int ack_cyc;
    ack_cyc = -1;
    @(negedge clk);
    req3 = 3'b010;
    adr3 = {32'h30, 32'h24, 32'h0};
    #1;
    chk("rst pre idle busy", {31'd0, busy3}, 32'd0);
    @(negedge clk); #1;
    chk("rst issue op", {31'd0, op3}, 32'd1);
    @(negedge clk); #1;
    chk("rst wait busy", {31'd0, busy3}, 32'd1);
    chk("rst wait op", {31'd0, op3}, 32'd0);
    #2;
    n_reset3 = 1'b0;
    #1;
    chk("rst busy", {31'd0, busy3}, 32'd0);
    chk("rst op", {31'd0, op3}, 32'd0);
    chk("rst ack", {29'd0, ack3}, 32'd0);
    chk("rst gnt_id", {29'd0, gnt3}, 32'd0);
    chk("rst mem_adr", madr3, 32'd0);
    @(negedge clk);
    req3 = 3'b110;
    n_reset3 = 1'b1;
    #1;
    chk("rearb starts idle", {31'd0, busy3}, 32'd0);
    @(negedge clk); #1;
    chk("rearb op", {31'd0, op3}, 32'd1);
    chk("rearb gnt pointer 1", {29'd0, gnt3}, 32'd1);
    chk("rearb mem_adr", madr3, 32'h24);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      if (ack3 != 3'b000) begin
        ack_cyc = c;
        chk("rearb ack vec", {29'd0, ack3}, 32'd2);
        break;
      end
    end
    chk("rearb ack seen", {31'd0, ack_cyc >= 0}, 32'd1);
    @(negedge clk);
    req3 = 3'b000;
  endtask

  initial begin
    fill_vectors();
    repeat (2) @(negedge clk);
    #1;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset mem_op", {31'd0, mem_op}, 32'd0);
    chk("reset gnt_id", {29'd0, gnt_id}, 32'd0);
    @(negedge clk);
    n_reset  = 1'b1;
    n_reset3 = 1'b1;
    run_table();
    lat3_read();
    lat3_reset();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
